cacheline_adapter: RTL and testbench
====================================

// Module: cacheline_adapter
// PURPOSE
//  Memory-side responder for the cache DFP interface: accepts 256-bit line reads/writes from cache
//  stage 2 and services them over the 64-bit burst memory (bmem) port as 4-beat bursts.
//  Sits between the cache and the burst memory model; exactly one line transaction in flight.
// PARAMETERS
//  LINE_BITS  256  cache line width; DFP data width
//  BEAT_BITS  64   bmem data width; BEATS = LINE_BITS/BEAT_BITS = 4; beat counter is 2 bits
// PORTS
//  clk          in   1    clock, all state updates on posedge
//  rst_n        in   1    asynchronous active-low reset
//  dfp_addr     in   32   line address; bits [4:0] ignored, forced to 0 when latched
//  dfp_read     in   1    line read request, held by cache until dfp_resp
//  dfp_write    in   1    line write request, held by cache until dfp_resp
//  dfp_wdata    in   256  write line, valid while dfp_write is high
//  dfp_rdata    out  256  read line, valid in the dfp_resp cycle of a read
//  dfp_resp     out  1    one-cycle completion pulse (read or write)
//  bmem_addr    out  32   burst address (line-aligned latched address)
//  bmem_read    out  1    one-cycle read burst request
//  bmem_write   out  1    write beat strobe, high for each of the 4 beats
//  bmem_wdata   out  64   current write beat
//  bmem_ready   in   1    memory can accept a request/beat this cycle
//  bmem_raddr   in   32   address tag of returning read beat
//  bmem_rdata   in   64   returning read beat
//  bmem_rvalid  in   1    read beat valid
// BEHAVIOUR
//  Reset: state IDLE; beat count 0; line buffer 0; all outputs 0. Asserting rst_n mid-burst aborts,
//   discards partial data, issues no dfp_resp; memory beats arriving after reset are ignored in IDLE.
//  States: IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP, GUARD.
//  IDLE: dfp_write -> latch {addr[31:5],5'b0}, wdata; go WR_BURST. Else dfp_read -> latch addr; go
//   RD_REQ. Both high: write wins (read not latched). bmem_rvalid in IDLE ignored.
//  RD_REQ: bmem_read=1, bmem_addr=latched addr; if bmem_ready -> RD_WAIT, else hold.
//  RD_WAIT: each accepted beat i (count 0..3) writes line[64*i +: 64]; count increments (wraps 3->0);
//   beat 3 -> RESP. No timeout.
//  WR_BURST: bmem_write=1, bmem_addr=latched addr, bmem_wdata=line[64*count +: 64]; count advances
//   only when bmem_ready=1; when ready=0, beat and strobe hold unchanged. 4th accepted beat -> RESP.
//  RESP: dfp_resp=1 one cycle; dfp_rdata=line buffer (reads; buffer also driven on writes,
//   content don't-care to the cache). -> GUARD.
//  GUARD: one cycle, dfp_read/dfp_write ignored (cache drops its request from a registered resp one
//   cycle late); -> IDLE. Back-to-back transactions therefore have >=2 idle cycles.
//  Latency (bmem_ready=1, read beats arriving from cycle N+2): read resp = 1+1+4+1 cycles after
//   request sampled; write resp = 4+1 cycles after request sampled.
//  bmem_read/bmem_write never high together; no output glitches: all outputs decoded from state regs.
//  dfp_addr/dfp_wdata changes after latch have no effect until next IDLE sample.
// CONFIGURATION
//  CACHELINE_ADAPTER_RADDR_CHECK_EN defined: in RD_WAIT a beat is accepted only if bmem_rvalid=1 and
//   bmem_raddr[31:5]==latched addr[31:5]; mismatching beats dropped, not counted.
//  Undefined: every bmem_rvalid beat in RD_WAIT accepted; bmem_raddr unused.
// TESTING
//  Read 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr 0x0000_1220, one bmem_read,
//   dfp_resp once, dfp_rdata = {0x44..,0x33..,0x22..,0x11..}.
//  Write 0x0000_0040, wdata {D3,D2,D1,D0}, ready=1 -> 4 bmem_write cycles D0,D1,D2,D3, then dfp_resp.
//  Write with bmem_ready low on beat 2 for 3 cycles -> D2 held 3 cycles, no beat skipped or
//   repeated, dfp_resp exactly once.
//  dfp_read held high 1 cycle past dfp_resp -> no second bmem_read (GUARD); new request after
//   GUARD starts a fresh transaction.
//  dfp_read&dfp_write same cycle -> write burst only, no bmem_read.
//  rst_n low after 2 read beats -> outputs 0, no dfp_resp; with RADDR_CHECK_EN, a beat with
//   bmem_raddr 0x0000_9990 during read of 0x0000_1220 is dropped and the line completes on 4 matches.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
// Signal bundle between the cache DFP port, the line adapter and the burst memory (bmem) port.
// slave is the adapter's view; master is the view of the cache plus memory environment.
interface cacheline_adapter_if #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64
);
    logic [31:0]          dfp_addr;
    logic                 dfp_read;
    logic                 dfp_write;
    logic [LINE_BITS-1:0] dfp_wdata;
    logic [LINE_BITS-1:0] dfp_rdata;
    logic                 dfp_resp;

    logic [31:0]          bmem_addr;
    logic                 bmem_read;
    logic                 bmem_write;
    logic [BEAT_BITS-1:0] bmem_wdata;
    logic                 bmem_ready;
    logic [31:0]          bmem_raddr;
    logic [BEAT_BITS-1:0] bmem_rdata;
    logic                 bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Services one cache line read/write at a time as a 4-beat burst on the bmem port.
// Optional CACHELINE_ADAPTER_RADDR_CHECK_EN: drop returning read beats whose line tag mismatches.
module cacheline_adapter #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64
) (
    input logic              clk,
    input logic              rst_n,
    cacheline_adapter_if.slave bus
);
    localparam int unsigned BEATS = LINE_BITS / BEAT_BITS;
    localparam int unsigned CntW  = $clog2(BEATS);
    localparam int unsigned OffW  = $clog2(LINE_BITS / 8);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrBurst,
        StResp,
        StGuard
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic                 beat_ok;
    logic                 last_beat;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    assign beat_ok = bus.bmem_rvalid && (bus.bmem_raddr[31:OffW] == addr_q[31:OffW]);
    logic unused_bits;
    assign unused_bits = ^{bus.dfp_addr[OffW-1:0], bus.bmem_raddr[OffW-1:0]};
`else
    assign beat_ok = bus.bmem_rvalid;
    logic unused_bits;
    assign unused_bits = ^{bus.dfp_addr[OffW-1:0], bus.bmem_raddr};
`endif

    assign last_beat = (cnt_q == CntW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        line_d          = line_q;
        bus.dfp_rdata   = '0;
        bus.dfp_resp    = 1'b0;
        bus.bmem_addr   = '0;
        bus.bmem_read   = 1'b0;
        bus.bmem_write  = 1'b0;
        bus.bmem_wdata  = '0;

        unique case (state_q)
            StIdle: begin
                // Write takes priority when both requests arrive together.
                if (bus.dfp_write) begin
                    addr_d  = {bus.dfp_addr[31:OffW], OffW'(0)};
                    line_d  = bus.dfp_wdata;
                    cnt_d   = '0;
                    state_d = StWrBurst;
                end else if (bus.dfp_read) begin
                    addr_d  = {bus.dfp_addr[31:OffW], OffW'(0)};
                    cnt_d   = '0;
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                bus.bmem_read = 1'b1;
                bus.bmem_addr = addr_q;
                if (bus.bmem_ready) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (beat_ok) begin
                    line_d[BEAT_BITS*cnt_q +: BEAT_BITS] = bus.bmem_rdata;
                    cnt_d = cnt_q + CntW'(1);
                    if (last_beat) begin
                        state_d = StResp;
                    end
                end
            end
            StWrBurst: begin
                bus.bmem_write = 1'b1;
                bus.bmem_addr  = addr_q;
                bus.bmem_wdata = line_q[BEAT_BITS*cnt_q +: BEAT_BITS];
                if (bus.bmem_ready) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (last_beat) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                bus.dfp_resp  = 1'b1;
                bus.dfp_rdata = line_q;
                state_d       = StGuard;
            end
            // The cache drops its request a cycle after resp; ignore it here.
            StGuard: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: vector table of line transactions, a memory model
// driven per cycle, and a scoreboard of expected bmem requests, write beats and responses.
module tb_cacheline_adapter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cacheline_adapter_if bus ();

    cacheline_adapter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic         wr;
        logic         both;
        logic         hold;
        logic         bad;
        int           stall_beat;
        int           stall_len;
        logic [31:0]  addr;
        logic [255:0] data;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_err    = 0;
    int n_rd     = 0;
    int n_resp   = 0;

    logic [31:0]  exp_rd_q[$];
    logic [95:0]  exp_wb_q[$];
    logic [256:0] exp_resp_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got unexpected event, want none", name);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bmem_read || bus.bmem_write)
                check("rd_wr_exclusive", 256'(bus.bmem_read & bus.bmem_write), 256'(0));
            if (bus.bmem_read && bus.bmem_ready) begin
                n_rd++;
                if (exp_rd_q.size() == 0) fail_now("unexpected_bmem_read");
                else check("bmem_addr_rd", 256'(bus.bmem_addr), 256'(exp_rd_q.pop_front()));
            end
            if (bus.bmem_write) begin
                if (exp_wb_q.size() == 0) fail_now("unexpected_bmem_write");
                else if (bus.bmem_ready)
                    check("bmem_wbeat", 256'({bus.bmem_addr, bus.bmem_wdata}),
                          256'(exp_wb_q.pop_front()));
                else
                    check("bmem_wbeat_held", 256'({bus.bmem_addr, bus.bmem_wdata}),
                          256'(exp_wb_q[0]));
            end
            if (bus.dfp_resp) begin
                logic [256:0] e;
                n_resp++;
                if (exp_resp_q.size() == 0) fail_now("unexpected_dfp_resp");
                else begin
                    e = exp_resp_q.pop_front();
                    if (e[256]) check("dfp_rdata", bus.dfp_rdata, e[255:0]);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dfp_resp"}, 256'(bus.dfp_resp), 256'(0));
        check({tag, "_dfp_rdata"}, bus.dfp_rdata, 256'(0));
        check({tag, "_bmem_read"}, 256'(bus.bmem_read), 256'(0));
        check({tag, "_bmem_write"}, 256'(bus.bmem_write), 256'(0));
        check({tag, "_bmem_addr"}, 256'(bus.bmem_addr), 256'(0));
        check({tag, "_bmem_wdata"}, 256'(bus.bmem_wdata), 256'(0));
    endtask

    task automatic run_txn(input vec_t v);
        logic [31:0] al;
        int          beat, wacc, stall_left, rd0, resp0, lat;
        bit          done, bad_sent;
        al    = {v.addr[31:5], 5'b0};
        rd0   = n_rd;
        resp0 = n_resp;
        if (v.wr) begin
            for (int i = 0; i < 4; i++) exp_wb_q.push_back({al, v.data[64*i +: 64]});
            exp_resp_q.push_back({1'b0, 256'(0)});
        end else begin
            exp_rd_q.push_back(al);
            exp_resp_q.push_back({1'b1, v.data});
        end
        @(posedge clk); #1;
        bus.dfp_addr  = v.addr;
        bus.dfp_wdata = v.wr ? v.data : 256'(0);
        bus.dfp_write = v.wr;
        bus.dfp_read  = !v.wr || v.both;
        beat = -1; wacc = 0; stall_left = v.stall_len; done = 0; lat = 0; bad_sent = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            lat = c + 1;
            if (c == 0) begin
                // Request is latched by now; later changes must not matter.
                bus.dfp_wdata = ~bus.dfp_wdata;
                bus.dfp_addr  = bus.dfp_addr ^ 32'hFFFF_0000;
            end
            bus.bmem_rvalid = 1'b0;
            bus.bmem_ready  = 1'b1;
            if (beat >= 0 && beat < 4) begin
                bus.bmem_rvalid = 1'b1;
                if (v.bad && beat == 2 && !bad_sent) begin
                    bus.bmem_raddr = 32'h0000_9990;
                    bus.bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    bad_sent = 1;
                end else begin
                    bus.bmem_raddr = al;
                    bus.bmem_rdata = v.data[64*beat +: 64];
                    beat++;
                end
            end
            if (bus.bmem_write && wacc == v.stall_beat && stall_left > 0) begin
                bus.bmem_ready = 1'b0;
                stall_left--;
            end
            if (bus.bmem_read && bus.bmem_ready) beat = 0;
            if (bus.bmem_write && bus.bmem_ready) wacc++;
            if (bus.dfp_resp) begin
                done = 1;
                if (!v.hold) begin
                    bus.dfp_read  = 1'b0;
                    bus.dfp_write = 1'b0;
                end
            end
        end
        bus.bmem_rvalid = 1'b0;
        bus.bmem_ready  = 1'b1;
        if (!done) begin
            fail_now("resp_timeout");
            exp_rd_q.delete(); exp_wb_q.delete(); exp_resp_q.delete();
        end
        if (v.hold) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            bus.dfp_read  = 1'b0;
            bus.dfp_write = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("resp_count", 256'(n_resp - resp0), 256'(1));
        check("bmem_read_count", 256'(n_rd - rd0), v.wr ? 256'(0) : 256'(1));
        if (v.wr && !v.both && v.stall_len == 0) check("wr_latency", 256'(lat), 256'(5));
    endtask

    task automatic reset_abort();
        logic [31:0] al;
        int          resp0;
        bit          seen;
        al    = 32'h0000_2000;
        resp0 = n_resp;
        exp_rd_q.push_back(al);
        @(posedge clk); #1;
        bus.dfp_addr = al;
        bus.dfp_read = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus.bmem_read) seen = 1;
        end
        if (!seen) fail_now("abort_no_bmem_read");
        for (int b = 0; b < 2; b++) begin
            @(posedge clk); #1;
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = al;
            bus.bmem_rdata  = 64'hAAAA_0000_0000_0000 | 64'(b);
        end
        @(posedge clk); #1;
        bus.bmem_rvalid = 1'b0;
        bus.dfp_read    = 1'b0;
        rst_n           = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_rd_q.delete(); exp_wb_q.delete(); exp_resp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Stray beat arriving in idle must be ignored.
        @(posedge clk); #1;
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        bus.bmem_rvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_resp", 256'(n_resp - resp0), 256'(0));
        check("abort_idle_bmem_read", 256'(bus.bmem_read), 256'(0));
    endtask

    initial begin
        vecs[0] = '{wr: 0, both: 0, hold: 0, bad: 0, stall_beat: -1, stall_len: 0,
                    addr: 32'h0000_1234,
                    data: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{wr: 1, both: 0, hold: 0, bad: 0, stall_beat: -1, stall_len: 0,
                    addr: 32'h0000_0040,
                    data: {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                           64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}};
        vecs[2] = '{wr: 1, both: 0, hold: 0, bad: 0, stall_beat: 2, stall_len: 3,
                    addr: 32'h0000_0080,
                    data: {64'hCAFE_0003_0003_0003, 64'hCAFE_0002_0002_0002,
                           64'hCAFE_0001_0001_0001, 64'hCAFE_0000_0000_0000}};
        vecs[3] = '{wr: 0, both: 0, hold: 1, bad: 0, stall_beat: -1, stall_len: 0,
                    addr: 32'h0000_301F,
                    data: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                           64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}};
        vecs[4] = '{wr: 0, both: 0, hold: 0, bad: 0, stall_beat: -1, stall_len: 0,
                    addr: 32'h0000_3040,
                    data: {64'h1000_0000_0000_0004, 64'h1000_0000_0000_0003,
                           64'h1000_0000_0000_0002, 64'h1000_0000_0000_0001}};
        vecs[5] = '{wr: 1, both: 1, hold: 0, bad: 0, stall_beat: -1, stall_len: 0,
                    addr: 32'h0000_5008,
                    data: {64'hB0B0_0000_0000_0003, 64'hB0B0_0000_0000_0002,
                           64'hB0B0_0000_0000_0001, 64'hB0B0_0000_0000_0000}};
        vecs[6] = '{wr: 0, both: 0, hold: 0, bad: 0, stall_beat: -1, stall_len: 0,
                    addr: 32'h0000_1220,
                    data: {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                           64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000}};
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
        vecs[6].bad = 1;
`endif

        bus.dfp_addr    = '0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.dfp_wdata   = '0;
        bus.bmem_ready  = 1'b1;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("post_reset_idle");

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        reset_abort();
        run_txn(vecs[0]);

        check("queues_drained",
              256'(exp_rd_q.size() + exp_wb_q.size() + exp_resp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
